// File: rtl/pc_seq_pkg.sv
// Shared state encodings and default parameter values for the PC sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    // Flat constants for code that keeps state in a plain logic vector.
    localparam logic [1:0] ST_BOOT = 2'(BOOT);
    localparam logic [1:0] ST_RUN  = 2'(RUN);
    localparam logic [1:0] ST_HALT = 2'(HALT);

    localparam int PC_WIDTH_DEF   = 8;
    localparam int PC_INC_DEF     = 4;
    localparam int RESET_VEC_DEF  = 0;
    localparam int ALIGN_BITS_DEF = 2;

endpackage

// File: rtl/pc_incrementer.sv
// Unsigned adder returning the sum and the carry out of the top bit.
module pc_incrementer #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    assign {c_out, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch handshake, redirects, halt/resume, sticky wrap flag.
// Optional macro PC_ALIGN_CHECK_EN: misaligned redirects are rejected and halt the core.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_WIDTH   = PC_WIDTH_DEF,
    parameter int PC_INC     = PC_INC_DEF,
    parameter int RESET_VEC  = RESET_VEC_DEF,
    parameter int ALIGN_BITS = ALIGN_BITS_DEF
) (
    input  logic                clk,
    input  logic                reset,
    output logic [PC_WIDTH-1:0] pc,
    output logic                pc_valid,
    input  logic                pc_ready,
    output logic [PC_WIDTH-1:0] pc_plus_inc,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_target,
    input  logic                halt_req,
    output logic                halted,
    output logic                pc_wrap,
    output logic                misalign_err
);

    localparam logic [PC_WIDTH-1:0] LOW_MASK = PC_WIDTH'((1 << ALIGN_BITS) - 1);
    localparam logic [PC_WIDTH-1:0] INC_VAL  = PC_WIDTH'(PC_INC);
    localparam logic [PC_WIDTH-1:0] RST_PC   = PC_WIDTH'(RESET_VEC);

    logic [1:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                wrap_q, wrap_d;
    logic                err_q, err_d;
    logic [PC_WIDTH-1:0] inc_sum;
    logic                inc_carry;
    logic [PC_WIDTH-1:0] target_aligned;
    logic                target_misaligned;
    logic                accept;

    pc_incrementer #(.WIDTH(PC_WIDTH)) u_inc (
        .a     (pc_q),
        .b     (INC_VAL),
        .sum   (inc_sum),
        .c_out (inc_carry)
    );

    assign target_aligned = redirect_target & ~LOW_MASK;
`ifdef PC_ALIGN_CHECK_EN
    assign target_misaligned = |(redirect_target & LOW_MASK);
`else
    assign target_misaligned = 1'b0;
`endif

    assign pc_valid     = (state_q == ST_RUN);
    assign halted       = (state_q == ST_HALT);
    assign accept       = pc_valid && pc_ready;
    assign pc           = pc_q;
    assign pc_plus_inc  = inc_sum;
    assign pc_wrap      = wrap_q;
    assign misalign_err = err_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        wrap_d  = wrap_q;
        err_d   = 1'b0;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                // Redirect beats accept; halt_req only changes state, so this cycle's PC update still lands.
                if (redirect_valid) begin
                    if (target_misaligned) begin
                        err_d   = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        pc_d = target_aligned;
                    end
                end else if (accept) begin
                    pc_d   = inc_sum;
                    wrap_d = wrap_q | inc_carry;
                end
                if (halt_req) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (redirect_valid) begin
                    if (target_misaligned) begin
                        err_d = 1'b1;
                    end else begin
                        pc_d    = target_aligned;
                        state_d = ST_RUN;
                    end
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RST_PC;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

endmodule
